// File: rtl/out_burst_ctrl.sv
// out_burst_ctrl: splits one decompressed page into 4 KB AXI write bursts with tail masking and B tracking
module out_burst_ctrl #(
  parameter int ADDR_W = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic [31:0]       length,
  input  logic              s_valid,
  input  logic [511:0]      s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic [ADDR_W-1:0] awaddr,
  output logic [7:0]        awlen,
  output logic              awvalid,
  input  logic              awready,
  output logic [511:0]      wdata,
  output logic [63:0]       wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  output logic              busy,
  output logic              done,
  output logic              error
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d, awaddr_q, awaddr_d;
  logic [25:0]       beats_q, beats_d, w_acc_q, w_acc_d;
  logic [19:0]       bursts_q, bursts_d, aw_cnt_q, aw_cnt_d, wb_cnt_q, wb_cnt_d, b_cnt_q, b_cnt_d;
  logic [5:0]        last_len_q, last_len_d, beat_q, beat_d;
  logic [6:0]        tail_q, tail_d;
  logic [7:0]        awlen_q, awlen_d;
  logic              awvalid_q, awvalid_d, error_q, error_d;
  logic              w_en, w_hs, b_hs, aw_hs, final_beat;
  logic [25:0]       st_beats, st_last;
  logic [19:0]       st_bursts;
  logic [5:0]        cur_len;
  logic              unused_bits;
  assign st_beats    = length[31:6] + 26'(|length[5:0]);
  assign st_last     = st_beats - 26'd1;
  assign st_bursts   = st_beats[25:6] + 20'(|st_beats[5:0]);
  assign unused_bits = ^{dest_addr[11:0], st_last[25:6]};
  assign w_en        = state_q == RUN && wb_cnt_q < aw_cnt_q;
  assign s_ready     = wready && w_en;
  assign wvalid      = s_valid && w_en;
  assign wdata       = s_data;
  assign w_hs        = s_valid && s_ready;
  assign aw_hs       = awvalid_q && awready;
  assign bready      = state_q == RUN || state_q == DRAIN;
  assign b_hs        = bvalid && bready;
  assign cur_len     = wb_cnt_q == bursts_q - 20'd1 ? last_len_q : 6'd63;
  assign wlast       = w_en && beat_q == cur_len;
  assign final_beat  = w_acc_q == beats_q - 26'd1;
  assign wstrb       = !w_en ? 64'd0 : final_beat ? ({64{1'b1}} >> (7'd64 - tail_q)) : {64{1'b1}};
  assign awvalid     = awvalid_q;
  assign awaddr      = awaddr_q;
  assign awlen       = awlen_q;
  assign busy        = state_q != IDLE;
  assign done        = state_q == FIN;
  assign error       = error_q;
  // next state, counters and the registered AW request; a new AW may follow its predecessor's handshake directly
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    beats_d    = beats_q;
    bursts_d   = bursts_q;
    last_len_d = last_len_q;
    tail_d     = tail_q;
    awaddr_d   = awaddr_q;
    awlen_d    = awlen_q;
    aw_cnt_d   = aw_cnt_q + 20'(aw_hs);
    wb_cnt_d   = wb_cnt_q + 20'(w_hs && wlast);
    b_cnt_d    = b_cnt_q + 20'(b_hs);
    w_acc_d    = w_acc_q + 26'(w_hs);
    beat_d     = w_hs ? (wlast ? 6'd0 : beat_q + 6'd1) : beat_q;
    awvalid_d  = awvalid_q && !awready;
    error_d    = error_q || (w_hs && s_last != wlast) || (b_hs && bresp != 2'b00);
    case (state_q)
      IDLE: if (start) begin
        state_d    = length == 32'd0 ? FIN : RUN;
        base_d     = {dest_addr[ADDR_W-1:12], 12'h0};
        beats_d    = st_beats;
        bursts_d   = st_bursts;
        last_len_d = st_last[5:0];
        tail_d     = length[5:0] == 6'd0 ? 7'd64 : {1'b0, length[5:0]};
        aw_cnt_d   = '0;
        wb_cnt_d   = '0;
        b_cnt_d    = '0;
        w_acc_d    = '0;
        beat_d     = '0;
        error_d    = 1'b0;
        awvalid_d  = length != 32'd0;
        awaddr_d   = {dest_addr[ADDR_W-1:12], 12'h0};
        awlen_d    = st_bursts == 20'd1 ? {2'b00, st_last[5:0]} : 8'd63;
      end
      RUN: begin
        if (w_hs && final_beat) state_d = DRAIN;
        if (!awvalid_d && aw_cnt_d < bursts_q && aw_cnt_d - b_cnt_d < 20'(MAX_OUTSTANDING)) begin
          awvalid_d = 1'b1;
          awaddr_d  = base_q + ADDR_W'({aw_cnt_d, 12'h0});
          awlen_d   = aw_cnt_d == bursts_q - 20'd1 ? {2'b00, last_len_q} : 8'd63;
        end
      end
      DRAIN: if (b_cnt_d == bursts_q) state_d = FIN;
      default: state_d = IDLE;
    endcase
  end
  // state register; reset clears everything on the next edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      beats_q    <= '0;
      bursts_q   <= '0;
      last_len_q <= '0;
      tail_q     <= '0;
      awaddr_q   <= '0;
      awlen_q    <= '0;
      aw_cnt_q   <= '0;
      wb_cnt_q   <= '0;
      b_cnt_q    <= '0;
      w_acc_q    <= '0;
      beat_q     <= '0;
      awvalid_q  <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      beats_q    <= beats_d;
      bursts_q   <= bursts_d;
      last_len_q <= last_len_d;
      tail_q     <= tail_d;
      awaddr_q   <= awaddr_d;
      awlen_q    <= awlen_d;
      aw_cnt_q   <= aw_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
      b_cnt_q    <= b_cnt_d;
      w_acc_q    <= w_acc_d;
      beat_q     <= beat_d;
      awvalid_q  <= awvalid_d;
      error_q    <= error_d;
    end
  end
endmodule

// File: tb/tb_out_burst_ctrl.sv
// tb_out_burst_ctrl: table, directed and random pages checked against a page-level model of the write scheduler
module tb_out_burst_ctrl;
  localparam int MAXO = 4;
  localparam logic [63:0] ONES = {64{1'b1}};
  logic clk = 1'b0;
  logic rst_n, start;
  logic [63:0] dest_addr;
  logic [31:0] length;
  logic s_valid, s_last, s_ready;
  logic [511:0] s_data, wdata;
  logic [63:0] awaddr, wstrb;
  logic [7:0] awlen;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready, busy, done, error;
  logic [1:0] bresp;

  out_burst_ctrl #(.ADDR_W(64), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dest_addr(dest_addr), .length(length),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // page model and slave knobs, owned by the main sequence
  longint exp_len;
  logic [63:0] exp_base;
  int exp_beats = 0, exp_bursts = 0, b_err = -1, sl_err = -1;
  logic exp_err;
  int aw_pct, w_pct, b_pct, src_pct, aw_low_until = 0;
  logic b_en;

  function automatic logic exp_wlast(input int n);
    int sz;
    sz = exp_beats - (n / 64) * 64;
    if (sz > 64) sz = 64;
    return (n % 64) == sz - 1;
  endfunction

  function automatic logic [63:0] exp_strb(input int n);
    logic [63:0] m;
    int t;
    m = '0;
    t = (exp_len % 64 == 0) ? 64 : int'(exp_len % 64);
    if (n != exp_beats - 1) return ONES;
    for (int b = 0; b < t; b++) m[b] = 1'b1;
    return m;
  endfunction

  function automatic logic [7:0] exp_awlen(input int i);
    int rem;
    rem = exp_beats - i * 64;
    return rem >= 64 ? 8'd63 : 8'(rem - 1);
  endfunction

  // monitor state, owned by the negedge monitor
  int aw_seen, w_beat, wb_done, b_seen, done_seen, start_cyc, done_cyc, last_b_cyc;
  logic w_hs_f, b_hs_f, aw_pend;
  logic [63:0] pend_addr, last_wstrb;
  logic [7:0] pend_len, last_awlen;
  int b_q[$];

  always @(negedge clk) begin
    if (!rst_n || (start && !busy)) begin
      aw_seen = 0; w_beat = 0; wb_done = 0; b_seen = 0; done_seen = 0;
      b_q.delete(); aw_pend = 0; w_hs_f = 0; b_hs_f = 0;
      last_awlen = 0; last_wstrb = 0; start_cyc = cyc; last_b_cyc = 0;
    end else begin
      if (aw_pend) chk("aw_stable", {awvalid, awaddr, awlen}, {1'b1, pend_addr, pend_len});
      if (s_ready) chk("sready_before_aw", wb_done < aw_seen, 1);
      w_hs_f = s_valid && s_ready;
      if (w_hs_f || (wvalid && wready)) chk("w_handshake", wvalid && wready, w_hs_f);
      if (w_hs_f) begin
        chk("w_order", wb_done < aw_seen, 1);
        chk("wlast", wlast, exp_wlast(w_beat));
        chk("wstrb", wstrb, exp_strb(w_beat));
        chk("wdata", wdata == s_data, 1);
        last_wstrb = wstrb;
        if (wlast) begin b_q.push_back(wb_done); wb_done++; end
        w_beat++;
      end
      b_hs_f = bvalid && bready;
      if (b_hs_f) begin
        chk("b_unexpected", b_seen < aw_seen, 1);
        b_seen++;
        last_b_cyc = cyc;
        if (b_q.size() > 0) void'(b_q.pop_front());
      end
      if (awvalid && awready) begin
        chk("aw_addr", awaddr, exp_base + 64'(aw_seen) * 64'd4096);
        chk("aw_len", awlen, exp_awlen(aw_seen));
        last_awlen = awlen;
        aw_seen++;
        chk("aw_extra", aw_seen <= exp_bursts, 1);
        chk("outstanding", (aw_seen - b_seen) <= MAXO, 1);
      end
      aw_pend = awvalid && !awready;
      pend_addr = awaddr;
      pend_len = awlen;
      if (done) begin
        done_seen++;
        done_cyc = cyc;
        if (exp_bursts > 0) chk("done_after_b", done_cyc, last_b_cyc + 1);
      end
    end
  end

  // AXI slave and stream source, driven just after each rising edge
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      awready = 0; wready = 0; bvalid = 0; bresp = 0; s_valid = 0; s_last = 0; s_data = '0;
    end else begin
      awready = cyc >= aw_low_until && $urandom_range(99) < aw_pct;
      wready = $urandom_range(99) < w_pct;
      if (bvalid && b_hs_f) bvalid = 0;
      else if (!bvalid && b_q.size() > 0 && b_en && $urandom_range(99) < b_pct) begin
        bvalid = 1;
        bresp = b_q[0] == b_err ? 2'b10 : 2'b00;
      end
      if (!s_valid || w_hs_f) begin
        s_valid = $urandom_range(99) < src_pct;
        for (int i = 0; i < 16; i++) s_data[i*32 +: 32] = $urandom;
      end
      if (w_beat >= exp_beats) s_valid = 0;
      s_last = exp_wlast(w_beat) ^ (w_beat == sl_err);
    end
  end

  task automatic set_page(input logic [63:0] a, input logic [31:0] l, input int be, input int se);
    exp_len = longint'(l);
    exp_base = a & ~64'hFFF;
    exp_beats = int'((exp_len + 63) / 64);
    exp_bursts = (exp_beats + 63) / 64;
    b_err = be;
    sl_err = se;
    exp_err = (be >= 0 && be < exp_bursts) || (se >= 0 && se < exp_beats);
  endtask

  task automatic pulse_start(input logic [63:0] a, input logic [31:0] l);
    @(posedge clk); #1 start = 1; dest_addr = a; length = l;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic finish_page(input int budget);
    int n;
    n = 0;
    while (done_seen == 0 && n < budget) begin @(posedge clk); n++; end
    chk("done_timeout", done_seen != 0, 1);
    repeat (3) @(posedge clk);
    chk("done_once", done_seen, 1);
    chk("aw_count", aw_seen, exp_bursts);
    chk("w_count", w_beat, exp_beats);
    chk("b_count", b_seen, exp_bursts);
    chk("error", error, exp_err);
    chk("busy_after", busy, 0);
  endtask

  typedef struct {
    logic [63:0] addr;
    logic [31:0] len;
    int          b_err;
    int          sl_err;
    int          bursts;
    logic [7:0]  awlen;
    logic [63:0] strb;
    logic        err;
  } vec_t;

  vec_t tv[10];
  logic [63:0] ra;
  logic [31:0] rl;
  int n;

  initial begin
    tv[0] = '{64'h1_0000_0000, 32'd4096,  -1, -1, 1, 8'd63, ONES, 1'b0};
    tv[1] = '{64'h2000_0000,   32'd100,   -1, -1, 1, 8'd1,  64'h0000_000F_FFFF_FFFF, 1'b0};
    tv[2] = '{64'h0,           32'd8192,   0, -1, 2, 8'd63, ONES, 1'b1};
    tv[3] = '{64'h3000,        32'd4096,  -1, 10, 1, 8'd63, ONES, 1'b1};
    tv[4] = '{64'h1234_5FFF,   32'd4097,  -1, -1, 2, 8'd0,  64'h1, 1'b0};
    tv[5] = '{64'h8000,        32'd1,     -1, -1, 1, 8'd0,  64'h1, 1'b0};
    tv[6] = '{64'h9000,        32'd64,    -1, -1, 1, 8'd0,  ONES, 1'b0};
    tv[7] = '{64'h10_0000,     32'd16192, -1, -1, 4, 8'd60, ONES, 1'b0};
    tv[8] = '{64'h5000,        32'd0,     -1, -1, 0, 8'd0,  64'h0, 1'b0};
    tv[9] = '{64'h7000,        32'd8191,  -1, -1, 2, 8'd63, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0};
    start = 0; dest_addr = 0; length = 0; b_en = 1;
    aw_pct = 70; w_pct = 80; b_pct = 60; src_pct = 80;
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_bready", bready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_wlast", wlast, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_awlen", awlen, 0);
    chk("rst_wstrb", wstrb, 0);
    @(posedge clk); #1 rst_n = 1;

    foreach (tv[i]) begin
      aw_pct = 70; w_pct = 80; b_pct = 60; src_pct = 80; b_en = 1;
      set_page(tv[i].addr, tv[i].len, tv[i].b_err, tv[i].sl_err);
      pulse_start(tv[i].addr, tv[i].len);
      finish_page(6000);
      chk("tbl_bursts", aw_seen, tv[i].bursts);
      if (tv[i].bursts != 0) begin
        chk("tbl_awlen", last_awlen, tv[i].awlen);
        chk("tbl_wstrb", last_wstrb, tv[i].strb);
      end
      chk("tbl_error", error, tv[i].err);
      if (tv[i].len == 0) chk("zero_len_latency", done_cyc - start_cyc >= 1 && done_cyc - start_cyc <= 2, 1);
    end

    // five bursts, address channel stalled then responses withheld: only four may be outstanding
    aw_pct = 100; w_pct = 100; src_pct = 100; b_pct = 100; b_en = 0;
    set_page(64'h0, 32'h5000, -1, -1);
    aw_low_until = cyc + 52;
    pulse_start(64'h0, 32'h5000);
    repeat (5) @(posedge clk);
    pulse_start(64'hDEAD_0000, 32'd64);
    repeat (30) @(posedge clk);
    chk("aw_blocked", aw_seen, 0);
    chk("aw_waiting", {awvalid, awaddr}, {1'b1, 64'h0});
    repeat (400) @(posedge clk);
    chk("aw_limit", aw_seen, 4);
    chk("w_limit", w_beat, 256);
    chk("no_5th_aw", awvalid, 0);
    chk("no_b_yet", b_seen, 0);
    b_en = 1;
    finish_page(3000);

    // reset in the middle of a page, then a short page
    set_page(64'h0, 32'd4096, -1, -1);
    pulse_start(64'h0, 32'd4096);
    n = 0;
    while (w_beat < 20 && n < 2000) begin @(posedge clk); n++; end
    chk("reach_beat20", w_beat >= 20, 1);
    #1 rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_awvalid", awvalid, 0);
    chk("mid_rst_wvalid", wvalid, 0);
    chk("mid_rst_busy", busy, 0);
    @(posedge clk); #1 rst_n = 1;
    set_page(64'h4000, 32'd64, -1, -1);
    pulse_start(64'h4000, 32'd64);
    finish_page(2000);

    for (int p = 0; p < 6; p++) begin
      aw_pct = $urandom_range(40, 100); w_pct = $urandom_range(40, 100);
      b_pct = $urandom_range(20, 100); src_pct = $urandom_range(40, 100);
      ra = {$urandom, $urandom} & 64'h0000_FFFF_FFFF_FFFF;
      rl = $urandom_range(0, 20000);
      set_page(ra, rl, ($urandom_range(2) == 0) ? int'($urandom_range(0, 4)) : -1,
               ($urandom_range(3) == 0) ? int'($urandom_range(0, 300)) : -1);
      pulse_start(ra, rl);
      finish_page(20000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
